dcm_prog_ctrl: RTL and testbench
================================

# dcm_prog_ctrl

User-input front end that drives the `dcm` clock manager's `update` and `prog_in` inputs. It debounces three raw push-buttons (up, down, load) and keeps a pending 3-bit frequency selection that saturates at 0 and 7. On a load press it issues a one-cycle `update` pulse with the pending value, then waits for the `dcm`'s `prog_out` to confirm the change. Sits directly upstream of `dcm` in the same 100 MHz `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles before a debounced button level changes (10 ms at 100 MHz); minimum 2.
- `ACK_TIMEOUT`, default 16: cycles allowed in WAIT for `prog_fb` to match before an error is flagged; minimum 2.
- `clk`  in  1  100 MHz reference clock; one clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `btn_up`  in  1  raw asynchronous button; increments the pending selection.
- `btn_down`  in  1  raw asynchronous button; decrements the pending selection.
- `btn_load`  in  1  raw asynchronous button; commits the pending selection to the `dcm`.
- `prog_fb`  in  3  feedback from the `dcm` `prog_out`.
- `prog_in`  out  3  registered selection presented to the `dcm`.
- `update`  out  1  one-cycle request pulse to the `dcm`.
- `pending`  out  3  current user selection, not yet committed.
- `busy`  out  1  high while the FSM is not in IDLE.
- `err`  out  1  sticky acknowledge-timeout flag.

## Operation
- **Synchronizer:** each button passes through a 2-FF synchronizer that resets to 0.
- **Debounce (per button):**
  - Counter and debounced level `db` both reset to 0.
  - When the synchronized input differs from `db`, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while the input still differs, `db` toggles on the next edge and the counter clears.
  - Any cycle where the input equals `db` clears the counter.
- **Press pulse:** `press = db & ~db_d`, where `db_d` is `db` delayed one cycle. It is high for exactly one cycle per debounced rising edge. Releases generate nothing.
- **Pending register:**
  - Resets to 0.
  - Up press: +1, saturating at 7.
  - Down press: -1, saturating at 0.
  - Up and down pressed in the same cycle: no change.
  - Up/down presses are accepted in every FSM state.
- **FSM states:** IDLE, ISSUE, WAIT. Resets to IDLE.
  - IDLE: load press -> ISSUE, capturing `pending` into `prog_in` on the same edge. Load presses outside IDLE are dropped.
  - ISSUE: `update`=1 for this single cycle. Clear the timeout counter. -> WAIT.
  - WAIT: the timeout counter increments each cycle.
    - `prog_fb == prog_in` -> IDLE and clear `err`.
    - Otherwise, when the counter reaches `ACK_TIMEOUT-1` -> IDLE and set `err`.
    - A match takes priority over timeout in the same cycle.
- **Same-cycle load and up/down:** `prog_in` takes the pre-increment `pending` value.
- **Reset values:** `prog_in`=0, `update`=0, `pending`=0, `busy`=0, `err`=0.
- **Reset mid-operation:** everything returns to reset values immediately (asynchronous), including an in-flight ISSUE/WAIT. No `update` is generated on reset release.

## Timing
- **Button latency:** with a button stable high from its first sampling edge E:
  - Synchronized level high at E+2.
  - `db` high at E+1+`DEBOUNCE_CYCLES`.
  - Press pulse valid during that cycle.
- **Pending:** updates one edge after the press pulse, i.e. visible at E+2+`DEBOUNCE_CYCLES`.
- **Load:** FSM enters ISSUE at E+2+`DEBOUNCE_CYCLES`, so `update` and the new `prog_in` are high/valid in the same cycle.
- **`update` shape:** exactly one cycle high, with at least 2 low cycles between pulses. This is guaranteed by ISSUE→WAIT→IDLE and satisfies the `dcm` edge detector.
- **`busy`:** high from the ISSUE cycle through the last WAIT cycle.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `db`.

## Test plan
- **Reset:** drive `rst`=0 mid-WAIT -> all outputs 0 the same cycle; after release, no `update` until a new load press.
- **Saturation:** `DEBOUNCE_CYCLES`=4; 9 clean up presses -> `pending` = 7; then 9 down presses -> 0; `prog_in` stays 0 throughout.
- **Bounce rejection:** toggle `btn_up` high for 3 cycles, low 1, repeated 10 times, then stable 20 cycles -> exactly one increment.
- **Commit:** `pending`=5, load press, `prog_fb` driven to 5 two cycles after `update` -> `update` one cycle, `prog_in`=5, `busy` high for 3 cycles, `err`=0.
- **Timeout:** `ACK_TIMEOUT`=8, `prog_fb` held at 0 with `prog_in`=3 -> `busy` high 9 cycles, `err`=1. A later successful commit clears `err`.
- **Load while busy:** load press during WAIT -> dropped, no second `update`. Up press in the same window -> `pending` increments.

Source files
------------

// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl: push-button front end for the dcm clock manager.
// Synchronizes and debounces up/down/load buttons, keeps a saturating 3-bit
// pending selection, and on a load press issues a one-cycle update with the
// committed selection, then waits for the dcm feedback to confirm it.
module dcm_prog_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACK_TIMEOUT     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic [2:0] prog_fb,
  output logic [2:0] prog_in,
  output logic       update,
  output logic [2:0] pending,
  output logic       busy,
  output logic       err
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  // Bit order for all per-button vectors: [0]=up, [1]=down, [2]=load.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  logic [2:0]      btn_raw;
  logic [2:0]      sync_p0;
  logic [2:0]      sync_p1;
  logic [2:0]      db;
  logic [2:0]      db_d;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];
  logic [TO_W-1:0] tmo_cnt;
  state_t          state;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  assign btn_raw = {btn_load, btn_down, btn_up};

  // --- stage p0/p1: two-flop synchronizer for the raw buttons ---
  // Bring the asynchronous buttons into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // --- stage db: debounce counters and press edge detection ---
  // Toggle each debounced level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      db_d <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_d;

  // --- stage sel: pending selection and commit FSM ---
  // Saturating pending selection; simultaneous up and down cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      case ({press[0], press[1]})
        2'b10:   pending <= sat_inc(pending);
        2'b01:   pending <= sat_dec(pending);
        default: pending <= pending;
      endcase
    end
  end

  // Commit FSM: capture pending on load, pulse update, wait for matching feedback or timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prog_in <= '0;
      update  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          if (press[2]) begin
            state   <= ISSUE;
            prog_in <= pending;
            update  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (prog_fb == prog_in) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b0;
          end else if (tmo_cnt == TO_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Self-checking bench for dcm_prog_ctrl with short debounce and timeout settings.
module tb_dcm_prog_ctrl;

  localparam int DC = 4;
  localparam int AT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_load = 1'b0;
  logic [2:0] prog_fb;
  logic [2:0] prog_in;
  logic       update;
  logic [2:0] pending;
  logic       busy;
  logic       err;

  int tests = 0;
  int fails = 0;

  // Reference state derived from the button/commit rules.
  int         exp_pend = 0;
  logic [2:0] exp_prog = 3'd0;
  logic       exp_err  = 1'b0;

  // Feedback responder settings.
  logic [2:0] fb_resp  = 3'd0;
  logic [2:0] fb_rest  = 3'd0;
  int         fb_delay = -1;
  logic       fb_go    = 1'b0;

  // Observation counters.
  int upd_total     = 0;
  int busy_run      = 0;
  int last_busy_len = 0;

  assign prog_fb = fb_go ? fb_resp : fb_rest;

  always #5 clk = ~clk;

  dcm_prog_ctrl #(.DEBOUNCE_CYCLES(DC), .ACK_TIMEOUT(AT)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .prog_fb  (prog_fb),
    .prog_in  (prog_in),
    .update   (update),
    .pending  (pending),
    .busy     (busy),
    .err      (err)
  );

  // Count update pulses and measure the length of each busy window.
  always @(negedge clk) begin
    if (update) upd_total++;
    if (busy) busy_run++;
    else if (busy_run > 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  // Emulated dcm: after an update, present fb_resp fb_delay cycles later (never if negative).
  always begin
    @(negedge clk);
    if (update) begin
      fb_go = 1'b0;
      if (fb_delay >= 0) begin
        repeat (fb_delay) @(posedge clk);
        #1 fb_go = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int step(int p, bit u, bit d);
    int n;
    n = p + (u ? 1 : 0) - (d ? 1 : 0);
    if (n > 7) n = 7;
    if (n < 0) n = 0;
    return n;
  endfunction

  // Clean press of the selected buttons, long enough to debounce both edges.
  task automatic press(input bit u, input bit d, input bit l);
    @(posedge clk); #1;
    btn_up = u; btn_down = d; btn_load = l;
    repeat (DC + 6) @(posedge clk);
    #1;
    btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0;
    repeat (DC + 12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pending(input int target);
    while (exp_pend < target) begin press(1, 0, 0); exp_pend = step(exp_pend, 1, 0); end
    while (exp_pend > target) begin press(0, 1, 0); exp_pend = step(exp_pend, 0, 1); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (prog_in !== 3'd0) begin fails++; $display("FAIL rst_prog_in: got %0d expected 0", prog_in); end
    tests++; if (update !== 1'b0) begin fails++; $display("FAIL rst_update: got %0b expected 0", update); end
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL rst_pending: got %0d expected 0", pending); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b expected 0", err); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    tests++; if (busy !== 1'b0 || pending !== 3'd0 || upd_total !== 0) begin
      fails++; $display("FAIL post_rst_idle: got busy=%0b pending=%0d updates=%0d expected 0/0/0", busy, pending, upd_total);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 9; k++) begin
      press(1, 0, 0);
      exp_pend = step(exp_pend, 1, 0);
      tests++; if (pending !== 3'(exp_pend)) begin fails++; $display("FAIL sat_up_%0d: got %0d expected %0d", k, pending, exp_pend); end
      tests++; if (prog_in !== 3'd0) begin fails++; $display("FAIL sat_up_prog_in_%0d: got %0d expected 0", k, prog_in); end
    end
    for (int k = 0; k < 9; k++) begin
      press(0, 1, 0);
      exp_pend = step(exp_pend, 0, 1);
      tests++; if (pending !== 3'(exp_pend)) begin fails++; $display("FAIL sat_dn_%0d: got %0d expected %0d", k, pending, exp_pend); end
      tests++; if (prog_in !== 3'd0) begin fails++; $display("FAIL sat_dn_prog_in_%0d: got %0d expected 0", k, prog_in); end
    end
    tests++; if (upd_total !== 0) begin fails++; $display("FAIL sat_no_update: got %0d expected 0", upd_total); end
  endtask

  task automatic test_bounce();
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      btn_up = 1'b1;
      repeat (3) @(posedge clk);
      #1 btn_up = 1'b0;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    tests++; if (pending !== 3'(exp_pend)) begin fails++; $display("FAIL bounce_glitch: got %0d expected %0d", pending, exp_pend); end
    @(posedge clk); #1;
    btn_up = 1'b1;
    repeat (20) @(posedge clk);
    #1 btn_up = 1'b0;
    repeat (DC + 12) @(posedge clk);
    @(negedge clk);
    exp_pend = step(exp_pend, 1, 0);
    tests++; if (pending !== 3'(exp_pend)) begin fails++; $display("FAIL bounce_one_inc: got %0d expected %0d", pending, exp_pend); end
  endtask

  task automatic test_random();
    int pick;
    bit u, d;
    for (int k = 0; k < 14; k++) begin
      pick = $urandom_range(0, 2);
      u = (pick != 1);
      d = (pick != 0);
      press(u, d, 0);
      exp_pend = step(exp_pend, u, d);
      tests++; if (pending !== 3'(exp_pend)) begin fails++; $display("FAIL rand_%0d(u=%0b,d=%0b): got %0d expected %0d", k, u, d, pending, exp_pend); end
    end
    tests++; if (prog_in !== exp_prog) begin fails++; $display("FAIL rand_prog_in: got %0d expected %0d", prog_in, exp_prog); end
  endtask

  task automatic test_commit();
    int u0;
    set_pending(5);
    fb_rest = 3'd0; fb_resp = 3'd5; fb_delay = 2;
    u0 = upd_total;
    press(0, 0, 1);
    exp_prog = 3'd5; exp_err = 1'b0;
    tests++; if (upd_total - u0 !== 1) begin fails++; $display("FAIL commit_updates: got %0d expected 1", upd_total - u0); end
    tests++; if (last_busy_len !== 3) begin fails++; $display("FAIL commit_busy_len: got %0d expected 3", last_busy_len); end
    tests++; if (prog_in !== exp_prog) begin fails++; $display("FAIL commit_prog_in: got %0d expected %0d", prog_in, exp_prog); end
    tests++; if (err !== exp_err || busy !== 1'b0) begin fails++; $display("FAIL commit_err_busy: got err=%0b busy=%0b expected 0/0", err, busy); end
  endtask

  task automatic test_timeout();
    int u0;
    set_pending(3);
    fb_rest = 3'd0; fb_delay = -1;
    u0 = upd_total;
    press(0, 0, 1);
    exp_prog = 3'd3; exp_err = 1'b1;
    tests++; if (upd_total - u0 !== 1) begin fails++; $display("FAIL tmo_updates: got %0d expected 1", upd_total - u0); end
    tests++; if (last_busy_len !== AT + 1) begin fails++; $display("FAIL tmo_busy_len: got %0d expected %0d", last_busy_len, AT + 1); end
    tests++; if (err !== exp_err) begin fails++; $display("FAIL tmo_err: got %0b expected 1", err); end
    tests++; if (prog_in !== exp_prog) begin fails++; $display("FAIL tmo_prog_in: got %0d expected %0d", prog_in, exp_prog); end
    fb_resp = 3'd3; fb_delay = 1;
    u0 = upd_total;
    press(0, 0, 1);
    exp_err = 1'b0;
    tests++; if (err !== exp_err) begin fails++; $display("FAIL tmo_err_clear: got %0b expected 0", err); end
    tests++; if (last_busy_len !== 2) begin fails++; $display("FAIL tmo_fast_busy_len: got %0d expected 2", last_busy_len); end
    tests++; if (upd_total - u0 !== 1) begin fails++; $display("FAIL tmo_fast_updates: got %0d expected 1", upd_total - u0); end
  endtask

  task automatic test_load_busy();
    int u0;
    fb_rest = 3'd0; fb_delay = -1;
    u0 = upd_total;
    // First press: shortest clean pulse, then an immediate second load (with up) that debounces inside WAIT.
    @(posedge clk); #1 btn_load = 1'b1;
    repeat (DC) @(posedge clk);
    #1 btn_load = 1'b0;
    repeat (DC) @(posedge clk);
    #1 btn_load = 1'b1; btn_up = 1'b1;
    repeat (DC + 6) @(posedge clk);
    #1 btn_load = 1'b0; btn_up = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    exp_pend = step(exp_pend, 1, 0);
    exp_err = 1'b1;
    tests++; if (upd_total - u0 !== 1) begin fails++; $display("FAIL busy_load_updates: got %0d expected 1", upd_total - u0); end
    tests++; if (pending !== 3'(exp_pend)) begin fails++; $display("FAIL busy_up_pending: got %0d expected %0d", pending, exp_pend); end
    tests++; if (prog_in !== exp_prog) begin fails++; $display("FAIL busy_prog_in: got %0d expected %0d", prog_in, exp_prog); end
    tests++; if (err !== exp_err || busy !== 1'b0) begin fails++; $display("FAIL busy_err_busy: got err=%0b busy=%0b expected 1/0", err, busy); end
  endtask

  task automatic test_same_cycle();
    int u0;
    fb_resp = 3'(exp_pend); fb_delay = 1;
    u0 = upd_total;
    exp_prog = 3'(exp_pend);
    press(1, 0, 1);
    exp_pend = step(exp_pend, 1, 0);
    exp_err = 1'b0;
    tests++; if (prog_in !== exp_prog) begin fails++; $display("FAIL same_prog_in: got %0d expected %0d", prog_in, exp_prog); end
    tests++; if (pending !== 3'(exp_pend)) begin fails++; $display("FAIL same_pending: got %0d expected %0d", pending, exp_pend); end
    tests++; if (err !== exp_err || upd_total - u0 !== 1) begin
      fails++; $display("FAIL same_err_upd: got err=%0b updates=%0d expected 0/1", err, upd_total - u0);
    end
  endtask

  task automatic test_reset_mid();
    int u0;
    bit seen;
    fb_rest = 3'd0; fb_delay = -1;
    seen = 1'b0;
    @(posedge clk); #1 btn_load = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (update) seen = 1'b1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL midrst_update_seen: got no update within 40 cycles, expected one"); end
    @(posedge clk); #2;
    btn_load = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %0b expected 1", busy); end
    rst = 1'b0;
    #1;
    tests++; if (prog_in !== 3'd0 || update !== 1'b0 || pending !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs: got prog_in=%0d update=%0b pending=%0d busy=%0b err=%0b expected all 0",
                        prog_in, update, pending, busy, err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    u0 = upd_total;
    exp_pend = 0; exp_prog = 3'd0; exp_err = 1'b0;
    repeat (30) @(negedge clk);
    tests++; if (upd_total !== u0) begin fails++; $display("FAIL midrst_no_update: got %0d expected %0d", upd_total, u0); end
    tests++; if (busy !== 1'b0 || pending !== 3'(exp_pend) || prog_in !== exp_prog) begin
      fails++; $display("FAIL midrst_idle: got busy=%0b pending=%0d prog_in=%0d expected 0/0/0", busy, pending, prog_in);
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_bounce();
    test_random();
    test_commit();
    test_timeout();
    test_load_busy();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
